serial_symbol_rx: RTL

- Serial-to-parallel front end for the parity-check stage.
- Receives an asynchronous, idle-high serial line and frames each character as 1 start bit, 8 symbol bits (LSB first, bit 7 is the odd-parity bit), and 1 stop bit.
- Presents each completed 8-bit symbol with a one-cycle valid strobe, directly consumable by the downstream parity checker.
- Flags framing errors.

---
 rtl/serial_symbol_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_symbol_rx.sv
// serial_symbol_rx: 8-bit serial receiver (start, 8 LSB-first bits, stop).
// Presents each good symbol with a one-cycle strobe and flags bad stop bits.
`default_nettype none

module serial_symbol_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] symbol,
   output logic       symbol_valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   logic             rx_m;
   logic             rx_s;
   logic             rx_d;
   logic [2:0]       settle;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   // The synchronizer leaves reset at 1, so a line already low would look
   // like a falling edge; settle masks edge detection until the chain has
   // been refilled with real line samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_d   <= 1'b1;
         settle <= 3'b000;
      end else begin
         rx_m   <= rx_in;
         rx_s   <= rx_m;
         rx_d   <= rx_s;
         settle <= {settle[1:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= 3'd0;
         shreg        <= 8'h00;
         symbol       <= 8'h00;
         symbol_valid <= 1'b0;
         frame_err    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         symbol_valid <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (settle[2] && rx_d && !rx_s) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (rx_s) begin
                     symbol       <= shreg;
                     symbol_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
